// File: rtl/beep_tone_gen.sv
// rtl/beep_tone_gen.sv - multi-channel square-wave tone generator with glitch-free note queueing
// Each channel runs an IDLE/PLAY FSM; new notes wait in a 1-deep pending slot until a period boundary.
module beep_tone_gen #(
  parameter int NCH    = 2,
  parameter int DIV_W  = 32,
  parameter int DUTY_W = 8,
  parameter int LEN_W  = 16,
  parameter int MIX    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          load,
  input  logic [NCH*DIV_W-1:0]    div,
  input  logic [NCH*DUTY_W-1:0]   duty,
  input  logic [NCH*LEN_W-1:0]    len,
  output logic [NCH-1:0]          busy,
  output logic [NCH-1:0]          done,
  output logic [NCH-1:0]          wave,
  output logic                    beep
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  localparam int PW = DIV_W + DUTY_W;
  localparam logic [DIV_W-1:0] D_ONE = 1;
  localparam logic [LEN_W-1:0] L_ONE = 1;

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch
    state_t             state, state_nx;
    logic [DIV_W-1:0]   d_in, lo_in, cnt, d_r, lo_r, pd_r, plo_r, ed, elo;
    logic [DUTY_W-1:0]  duty_in;
    logic [LEN_W-1:0]   l_in, per, l_r, pl_r, el;
    logic [PW-1:0]      prod;
    logic               valid_in, pv_r, ev, wrap, last, done_nx;
    logic               done_r, wave_r, busy_c, done_c, wave_c;

    assign d_in     = div[g*DIV_W +: DIV_W];
    assign duty_in  = duty[g*DUTY_W +: DUTY_W];
    assign l_in     = len[g*LEN_W +: LEN_W];
    assign prod     = {{DUTY_W{1'b0}}, d_in} * {{DIV_W{1'b0}}, duty_in};
    // Low time first: LO = D - high time, so duty=0 leaves the wave silent.
    assign lo_in    = d_in - DIV_W'(prod >> DUTY_W);
    assign valid_in = (d_in > D_ONE) && (l_in != '0);
    assign wrap     = (state == PLAY) && (cnt == d_r - D_ONE);
    assign last     = wrap && (per == l_r - L_ONE);

    // A load in this very cycle overrides whatever is already pending.
    always_comb begin
      ev  = pv_r;
      ed  = pd_r;
      elo = plo_r;
      el  = pl_r;
      if (load[g]) begin
        ev  = valid_in;
        ed  = d_in;
        elo = lo_in;
        el  = l_in;
      end
    end

    assign done_nx = (load[g] && !valid_in) || (last && !ev);

    always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
    end

    always_comb begin
      state_nx = state;
      case (state)
        IDLE:    if (load[g] && valid_in) state_nx = PLAY;
        PLAY:    if (last && !ev)         state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end

    always_comb begin
      busy_c = (state == PLAY);
      done_c = done_r;
      wave_c = wave_r;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt    <= '0;
        per    <= '0;
        d_r    <= '0;
        lo_r   <= '0;
        l_r    <= '0;
        pv_r   <= 1'b0;
        pd_r   <= '0;
        plo_r  <= '0;
        pl_r   <= '0;
        done_r <= 1'b0;
        wave_r <= 1'b0;
      end else begin
        done_r <= done_nx;
        wave_r <= (state == PLAY) && (cnt >= lo_r);
        if (state == IDLE) begin
          if (load[g] && valid_in) begin
            d_r  <= d_in;
            lo_r <= lo_in;
            l_r  <= l_in;
          end
          cnt  <= '0;
          per  <= '0;
          pv_r <= 1'b0;
        end else if (wrap && ev) begin
          d_r  <= ed;
          lo_r <= elo;
          l_r  <= el;
          cnt  <= '0;
          per  <= '0;
          pv_r <= 1'b0;
        end else begin
          pv_r  <= ev;
          pd_r  <= ed;
          plo_r <= elo;
          pl_r  <= el;
          if (wrap) begin
            cnt <= '0;
            per <= per + L_ONE;
          end else begin
            cnt <= cnt + D_ONE;
          end
        end
      end
    end

    assign busy[g] = busy_c;
    assign done[g] = done_c;
    assign wave[g] = wave_c;
  end

  always_ff @(posedge clk) begin
    if (!rst)          beep <= 1'b0;
    else if (MIX != 0) beep <= ^wave;
    else               beep <= |wave;
  end

endmodule
